// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard using inhibit, request-to-send and 11 device-clocked bits.
// Latency: the clock is inhibited for INHIBIT_US, then the device paces the transfer; done/error pulse once both lines are idle again.
// Backpressure: tx_ready is high only in IDLE; tx_valid presented while busy is ignored and must be re-presented later.
//
// Ports:
//   CLK_CPU, resetn            : clock (rising edge), synchronous active-low reset
//   tx_data/tx_valid/tx_ready  : byte request handshake, tx_data sampled on accept
//   tx_done/tx_error           : one-cycle completion pulses, mutually exclusive
//   ps2_clk_in/ps2_data_in     : raw open-drain line levels
//   ps2_clk_oe/ps2_data_oe     : 1 pulls the line low, 0 releases it
// Build option: define PS2_TX_ACK_CHECK_EN to report a missing device acknowledge as tx_error.
module ps2_host_tx #(
  parameter int CLK_HZ     = 16000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000
) (
  input  logic       CLK_CPU,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INHIBIT_CYC = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int INH_W       = $clog2(INHIBIT_CYC + 1);
  localparam int WDG_W       = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Line synchronizers; r_clk_prev holds the previous synced clock for edge detection.
  logic r_clk_meta, r_clk_sync, r_clk_prev;
  logic r_dat_meta, r_dat_sync;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic [3:0]       r_bitcnt, w_bitcnt_nxt;
  logic [INH_W-1:0] r_inh_cnt, w_inh_cnt_nxt;
  logic [WDG_W-1:0] r_wdog, w_wdog_nxt;
  logic             r_clk_oe, w_clk_oe_nxt;
  logic             r_data_oe, w_data_oe_nxt;
  logic             r_done, w_done_nxt;
  logic             r_error, w_error_nxt;
`ifdef PS2_TX_ACK_CHECK_EN
  logic             r_ack_ok, w_ack_ok_nxt;
`endif

  logic       w_fall;
  logic [3:0] w_bitn;
  logic       w_wdog_run;
  logic       w_timeout;

  assign w_fall     = r_clk_prev & ~r_clk_sync;
  // Number of the device falling edge being handled right now (1-based).
  assign w_bitn     = r_bitcnt + 4'd1;
  assign w_wdog_run = (r_state == S_RTS) || (r_state == S_SHIFT) ||
                      (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  // The counter is zero in the first RTS cycle, so matching TIMEOUT_CYC-1
  // lands the abort exactly TIMEOUT_CYC cycles after RTS entry.
  assign w_timeout  = w_wdog_run && (r_wdog == WDG_W'(TIMEOUT_CYC - 1));

  assign tx_ready    = (r_state == S_IDLE);
  assign tx_done     = r_done;
  assign tx_error    = r_error;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

  always_ff @(posedge CLK_CPU) begin
    if (!resetn) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_state    <= S_IDLE;
      r_byte     <= '0;
      r_bitcnt   <= '0;
      r_inh_cnt  <= '0;
      r_wdog     <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      r_ack_ok   <= 1'b0;
`endif
    end else begin
      r_clk_meta <= ps2_clk_in;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_data_in;
      r_dat_sync <= r_dat_meta;
      r_state    <= w_state_nxt;
      r_byte     <= w_byte_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_inh_cnt  <= w_inh_cnt_nxt;
      r_wdog     <= w_wdog_nxt;
      r_clk_oe   <= w_clk_oe_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
`ifdef PS2_TX_ACK_CHECK_EN
      r_ack_ok   <= w_ack_ok_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_byte_nxt    = r_byte;
    w_bitcnt_nxt  = r_bitcnt;
    w_inh_cnt_nxt = r_inh_cnt;
    w_wdog_nxt    = '0;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_done_nxt    = 1'b0;
    w_error_nxt   = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    w_ack_ok_nxt  = r_ack_ok;
`endif

    if (w_wdog_run) begin
      w_wdog_nxt = r_wdog + WDG_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (tx_valid) begin
          w_byte_nxt    = tx_data;
          w_bitcnt_nxt  = '0;
          w_inh_cnt_nxt = '0;
          w_clk_oe_nxt  = 1'b1;
          w_state_nxt   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (r_inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
          w_data_oe_nxt = 1'b1;      // start bit, clock still held low
          w_state_nxt   = S_RTS;
        end else begin
          w_inh_cnt_nxt = r_inh_cnt + INH_W'(1);
        end
      end
      S_RTS: begin
        w_clk_oe_nxt = 1'b0;         // hand the clock to the device
        w_state_nxt  = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_fall) begin
          w_bitcnt_nxt = w_bitn;
          if (w_bitn <= 4'd8) begin
            w_data_oe_nxt = ~r_byte[r_bitcnt[2:0]];
          end else if (w_bitn == 4'd9) begin
            // Odd parity bit is ~^byte; pulling low means driving its inverse.
            w_data_oe_nxt = ^r_byte;
          end else begin
            w_data_oe_nxt = 1'b0;    // stop bit: release data
            w_state_nxt   = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_bitcnt_nxt = w_bitn;
`ifdef PS2_TX_ACK_CHECK_EN
          w_ack_ok_nxt = ~r_dat_sync;
`endif
          w_state_nxt  = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // Further device edges are not counted here.
        if (r_clk_sync && r_dat_sync) begin
          w_state_nxt = S_IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
          w_done_nxt  = r_ack_ok;
          w_error_nxt = ~r_ack_ok;
`else
          w_done_nxt  = 1'b1;
`endif
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
      end
    endcase

    // Watchdog overrides everything so done and error can never coincide.
    if (w_timeout) begin
      w_state_nxt   = S_IDLE;
      w_clk_oe_nxt  = 1'b0;
      w_data_oe_nxt = 1'b0;
      w_done_nxt    = 1'b0;
      w_error_nxt   = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int CLK_HZ     = 16000000;
  localparam int INHIBIT_US = 100;
  localparam int TIMEOUT_US = 1000;
  localparam int INH_CYC    = CLK_HZ / 1000000 * INHIBIT_US;   // 1600
  localparam int TO_CYC     = CLK_HZ / 1000000 * TIMEOUT_US;   // 16000
`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic       CLK_CPU = 1'b0;
  logic       resetn  = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  // Open-drain wired-AND of host and keyboard.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_dat & ~ps2_data_oe;

  ps2_host_tx #(.CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .TIMEOUT_US(TIMEOUT_US)) dut (
    .CLK_CPU(CLK_CPU), .resetn(resetn), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe));

  always #5 CLK_CPU = ~CLK_CPU;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge CLK_CPU) cyc <= cyc + 1;

  // Passive monitor: pulse counts, inhibit/RTS widths and timestamps.
  int n_done = 0, n_err = 0, err_cyc = 0, rts_cyc = 0;
  int inh_run = 0, inh_len = 0, rts_run = 0, rts_len = 0;
  logic [2:0] err_lines = 3'b000;
  bit both_seen = 1'b0;
  always @(negedge CLK_CPU) begin
    if (tx_done) n_done++;
    if (tx_error) begin
      n_err++;
      err_cyc   = cyc;
      err_lines = {ps2_clk_oe, ps2_data_oe, tx_ready};
    end
    if (tx_done && tx_error) both_seen = 1'b1;
    if (ps2_clk_oe && !ps2_data_oe) inh_run++;
    else if (ps2_clk_oe && ps2_data_oe && inh_run != 0) begin
      inh_len = inh_run; rts_cyc = cyc; inh_run = 0;
    end else inh_run = 0;
    if (ps2_clk_oe && ps2_data_oe) rts_run++;
    else if (rts_run != 0) begin rts_len = rts_run; rts_run = 0; end
  end

  // Reference frame as the keyboard sees it: {stop, odd parity, data LSB first}.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  task automatic tick();
    @(posedge CLK_CPU); #1;
  endtask

  task automatic send_req(input logic [7:0] b);
    int w = 0;
    while (!tx_ready && w < 5000) begin tick(); w++; end
    tx_data = b; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for request-to-send, then produces nclk clock pulses
  // and samples the data line just before each rising edge.
  task automatic dev_xfer(input int nclk, input bit ack, input int hp,
                          output logic [10:0] got, output bit ok);
    int w = 0;
    got = '1;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && w < INH_CYC + 200) begin
      tick(); w++;
    end
    ok = (ps2_clk_in === 1'b1 && ps2_data_in === 1'b0);
    if (ok) begin
      got[0] = ps2_data_in;
      for (int k = 1; k <= nclk; k++) begin
        if (k == 11) dev_dat = ack ? 1'b0 : 1'b1;
        repeat (hp) tick();
        dev_clk = 1'b0;
        repeat (hp) tick();
        if (k <= 10) got[k] = ps2_data_in;
        dev_clk = 1'b1;
      end
      repeat (hp) tick();
      dev_dat = 1'b1;
    end
  endtask

  task automatic xfer(input logic [7:0] b, input bit ack, input int hp,
                      output logic [10:0] got, output int nd, output int ne, output bit ok);
    int d0, e0, w;
    d0 = n_done; e0 = n_err; w = 0;
    send_req(b);
    dev_xfer(11, ack, hp, got, ok);
    while (!tx_ready && w < 300) begin tick(); w++; end
    repeat (3) tick();
    nd = n_done - d0; ne = n_err - e0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    tests++; if (ps2_clk_oe !== 1'b0) begin fails++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
    tests++; if (ps2_data_oe !== 1'b0) begin fails++; $display("FAIL reset_data_oe got=%b exp=0", ps2_data_oe); end
    tests++; if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    tests++; if (tx_error !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", tx_error); end
    resetn = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_send_ed();
    logic [10:0] got; int nd, ne; bit ok;
    xfer(8'hED, 1'b1, 20, got, nd, ne, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL ed_rts_seen got=%b exp=1", ok); end
    tests++; if (got[8:1] !== 8'b1110_1101) begin fails++; $display("FAIL ed_data_bits got=%b exp=%b", got[8:1], 8'b1110_1101); end
    tests++; if (got[9] !== 1'b1) begin fails++; $display("FAIL ed_parity got=%b exp=1", got[9]); end
    tests++; if (got[10] !== 1'b1) begin fails++; $display("FAIL ed_stop got=%b exp=1", got[10]); end
    tests++; if (inh_len != INH_CYC) begin fails++; $display("FAIL ed_inhibit_len got=%0d exp=%0d", inh_len, INH_CYC); end
    tests++; if (rts_len != 1) begin fails++; $display("FAIL ed_rts_len got=%0d exp=1", rts_len); end
    tests++; if (nd != 1 || ne != 0) begin fails++; $display("FAIL ed_result got done=%0d err=%0d exp done=1 err=0", nd, ne); end
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL ed_ready_back got=%b exp=1", tx_ready); end
  endtask

  task automatic test_parity();
    logic [10:0] got; int nd, ne; bit ok;
    xfer(8'h01, 1'b1, 12, got, nd, ne, ok);
    tests++; if (got[9] !== 1'b0) begin fails++; $display("FAIL parity_01 got=%b exp=0", got[9]); end
    tests++; if (got[10:1] !== exp_frame(8'h01)) begin fails++; $display("FAIL frame_01 got=%h exp=%h", got[10:1], exp_frame(8'h01)); end
    xfer(8'hFF, 1'b1, 12, got, nd, ne, ok);
    tests++; if (got[9] !== 1'b1) begin fails++; $display("FAIL parity_ff got=%b exp=1", got[9]); end
    tests++; if (nd != 1) begin fails++; $display("FAIL parity_ff_done got=%0d exp=1", nd); end
  endtask

  task automatic test_no_ack();
    logic [10:0] got; int nd, ne; bit ok; logic [7:0] b;
    b = 8'($urandom);
    xfer(b, 1'b0, 15, got, nd, ne, ok);
    tests++; if (got[10:1] !== exp_frame(b)) begin fails++; $display("FAIL noack_frame got=%h exp=%h", got[10:1], exp_frame(b)); end
    tests++;
    if (nd != (ACK_CHK ? 0 : 1) || ne != (ACK_CHK ? 1 : 0)) begin
      fails++; $display("FAIL noack_result got done=%0d err=%0d exp done=%0d err=%0d", nd, ne, ACK_CHK ? 0 : 1, ACK_CHK ? 1 : 0);
    end
  endtask

  task automatic test_random();
    logic [10:0] got; int nd, ne, ed, ee; bit ok, ack; logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      ack = 1'($urandom_range(0, 3) != 0);
      xfer(b, ack, $urandom_range(8, 25), got, nd, ne, ok);
      ed = (ack || !ACK_CHK) ? 1 : 0;
      ee = 1 - ed;
      tests++; if (got[10:1] !== exp_frame(b)) begin fails++; $display("FAIL rand_frame[%0d] got=%h exp=%h", i, got[10:1], exp_frame(b)); end
      tests++; if (nd != ed || ne != ee) begin fails++; $display("FAIL rand_result[%0d] got done=%0d err=%0d exp done=%0d err=%0d", i, nd, ne, ed, ee); end
    end
  endtask

  task automatic test_timeout();
    logic [10:0] got; bit ok; int d0, e0, w;
    d0 = n_done; e0 = n_err; w = 0;
    send_req(8'h55);
    dev_xfer(0, 1'b1, 5, got, ok);
    while (n_err == e0 && w < TO_CYC + 100) begin tick(); w++; end
    tick();
    tests++; if (n_err - e0 != 1) begin fails++; $display("FAIL timeout_error got=%0d exp=1", n_err - e0); end
    tests++; if (err_cyc - rts_cyc != TO_CYC) begin fails++; $display("FAIL timeout_delay got=%0d exp=%0d", err_cyc - rts_cyc, TO_CYC); end
    tests++; if (err_lines !== 3'b001) begin fails++; $display("FAIL timeout_lines got=%b exp=001", err_lines); end
    tests++; if (n_done != d0) begin fails++; $display("FAIL timeout_no_done got=%0d exp=0", n_done - d0); end
  endtask

  task automatic test_busy_ignore();
    logic [10:0] got; bit ok; int d0, w, busy;
    d0 = n_done; w = 0; busy = 0;
    send_req(8'hED);
    fork
      dev_xfer(11, 1'b1, 20, got, ok);
      begin
        repeat (INH_CYC + 100) tick();
        tx_data = 8'hF4; tx_valid = 1'b1;
        repeat (30) tick();
        tx_valid = 1'b0;
      end
    join
    while (!tx_ready && w < 300) begin tick(); w++; end
    tests++; if (got[10:1] !== exp_frame(8'hED)) begin fails++; $display("FAIL busy_frame got=%h exp=%h", got[10:1], exp_frame(8'hED)); end
    for (int i = 0; i < 50; i++) begin tick(); if (ps2_clk_oe || !tx_ready) busy++; end
    tests++; if (busy != 0) begin fails++; $display("FAIL busy_no_restart got=%0d exp=0", busy); end
    tests++; if (n_done - d0 != 1) begin fails++; $display("FAIL busy_done got=%0d exp=1", n_done - d0); end
    begin
      int nd, ne;
      xfer(8'hF4, 1'b1, 14, got, nd, ne, ok);
      tests++; if (got[10:1] !== exp_frame(8'hF4)) begin fails++; $display("FAIL busy_f4_frame got=%h exp=%h", got[10:1], exp_frame(8'hF4)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got; bit ok; int d0, e0, nd, ne; logic [7:0] b;
    d0 = n_done; e0 = n_err;
    send_req(8'hA7);
    dev_xfer(4, 1'b1, 15, got, ok);
    resetn = 1'b0;
    tick();
    tests++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin fails++; $display("FAIL rstmid_lines got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
    repeat (2) tick();
    resetn = 1'b1;
    repeat (20) tick();
    tests++; if (n_done != d0 || n_err != e0) begin fails++; $display("FAIL rstmid_no_pulse got done=%0d err=%0d exp 0 0", n_done - d0, n_err - e0); end
    b = 8'($urandom);
    xfer(b, 1'b1, 18, got, nd, ne, ok);
    tests++; if (got[10:1] !== exp_frame(b) || nd != 1 || ne != 0) begin
      fails++; $display("FAIL rstmid_next got=%h done=%0d err=%0d exp=%h done=1 err=0", got[10:1], nd, ne, exp_frame(b));
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_no_ack();
    test_random();
    test_timeout();
    test_busy_ignore();
    test_reset_mid();
    tests++; if (both_seen !== 1'b0) begin fails++; $display("FAIL done_error_overlap got=%b exp=0", both_seen); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 16000000, CLK_CPU frequency in Hz.
REQ-002 SHALL have parameter INHIBIT_US, default 100, clock-inhibit time before request-to-send.
REQ-003 SHALL have parameter TIMEOUT_US, default 15000, maximum time from request-to-send to acknowledge.
REQ-004 SHALL have port CLK_CPU  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low; clock CLK_CPU.
REQ-006 SHALL have port tx_data  in  8  command byte to the keyboard, sampled on accept.
REQ-007 SHALL have port tx_valid  in  1  request to send tx_data.
REQ-008 SHALL have port tx_ready  out  1  high when idle and able to accept.
REQ-009 SHALL have port tx_done  out  1  one-cycle pulse on successful transfer.
REQ-010 SHALL have port tx_error  out  1  one-cycle pulse on timeout or missing acknowledge.
REQ-011 SHALL have ports ps2_clk_in and ps2_data_in  in  1 each  raw open-drain line levels.
REQ-012 SHALL have ports ps2_clk_oe and ps2_data_oe  out  1 each  1 = pull line low, 0 = release.

Function
REQ-013 SHALL pass ps2_clk_in and ps2_data_in through 2-FF synchronizers; a device falling edge is synced-previous 1, synced-current 0.
REQ-014 SHALL accept a byte on any edge with tx_valid & tx_ready; tx_ready low from the next cycle until return to IDLE; tx_valid while busy is ignored.
REQ-015 SHALL implement states IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-016 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly CLK_HZ/1000000*INHIBIT_US cycles (1600 at defaults), then RTS.
REQ-017 RTS: ps2_data_oe=1 (start bit) for one cycle with ps2_clk_oe=1, then ps2_clk_oe=0 and enter SHIFT.
REQ-018 SHIFT: on device falling edges 1..8 drive ps2_data_oe = ~tx_data[n-1] (LSB first); edge 9 drive ~parity, parity odd (= ~^tx_data); edge 10 release data (stop) and enter ACK.
REQ-019 ACK: on device falling edge 11 sample synced data; low = acknowledged, high = missing acknowledge; enter WAIT_IDLE.
REQ-020 WAIT_IDLE: wait until synced clock and data both high, then pulse tx_done (or tx_error if ack missing, see REQ-026) and return to IDLE.
REQ-021 Watchdog SHALL start at RTS entry; reaching CLK_HZ/1000000*TIMEOUT_US cycles (240000 at defaults) in RTS..WAIT_IDLE SHALL release both lines, pulse tx_error, return to IDLE.
REQ-022 Bit counter SHALL be 4 bits, cleared on accept; edges beyond 11 ignored.
REQ-023 tx_done and tx_error SHALL never assert in the same cycle.

Reset
REQ-024 While resetn low at a clock edge: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_done=0, tx_error=0, counters and synchronizers cleared to idle-high.
REQ-025 Reset mid-transfer SHALL abort without tx_done/tx_error pulse; lines released on the first edge with resetn low.

Configuration
REQ-026 Macro PS2_TX_ACK_CHECK_EN defined: missing acknowledge yields tx_error in place of tx_done; undefined: acknowledge level not checked, edge 11 always yields tx_done.

Verification
REQ-027 Send 0xED, keyboard model acks -> clk held low 1600 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, tx_done one pulse, tx_ready returns high.
REQ-028 Send 0x01 and 0xFF -> parity bits 0 and 1 respectively.
REQ-029 Model holds data high at edge 11 -> tx_error with PS2_TX_ACK_CHECK_EN, tx_done without.
REQ-030 Model never clocks after RTS -> tx_error exactly 240000 cycles after RTS entry, both oe 0, tx_ready 1.
REQ-031 tx_valid with 0xF4 asserted during SHIFT of 0xED -> ignored; 0xF4 sent only after re-presentation in IDLE.
REQ-032 resetn low during SHIFT bit 4 -> both oe 0 next edge, no done/error pulse, next transfer completes normally.
